// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned MUL_LAT_DEF  = 3;
  localparam int unsigned DIV_ITER_DEF = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MUL   = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Ops that occupy the sequencer and stall the pipeline.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
           (op == MD_DIVU) || (op == MD_MUL);
  endfunction

  // Ops that use the external multiplier.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MUL);
  endfunction

  // Ops whose operands are two's-complement.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MUL);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle after a start pulse.
module div_iter import muldiv_pkg::*; #(
  parameter int unsigned ITER = DIV_ITER_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    shifted_c;
  logic [XLEN:0]    diff_c;

  // Partial remainder shifted left by one with the next dividend bit, and the trial subtract.
  assign shifted_c = {rem_q, quo_q[XLEN-1]};
  assign diff_c    = shifted_c - {1'b0, dvs_q};

  // Load on start, then iterate until the counter drains; a borrow restores the remainder.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      cnt_q <= CNT_W'(ITER);
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (!diff_c[XLEN]) begin
        rem_q <= diff_c[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted_c[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, drives the external multiplier, embeds the divider.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned DIV_ITER = DIV_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              flush,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic [2*XLEN-1:0] mul_res,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             fix_c;

  muldiv_op_t       op_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;
  logic             mul_start_q;
  logic [XLEN-1:0]  mul_a_q, mul_b_q;
  logic [XLEN-1:0]  hi_q, lo_q, result_q;

  logic             a_neg_c, b_neg_c;
  logic [XLEN-1:0]  mag_a_c, mag_b_c;
  logic [XLEN-1:0]  quo_raw, rem_raw;
  logic [2*XLEN-1:0] prod_fix_c;
  logic [XLEN-1:0]  quo_fix_c, rem_fix_c;

  // Operand magnitudes; only signed ops treat bit 31 as a sign (so |-2^31| stays 0x80000000).
  assign a_neg_c = is_signed_op(req_op) & a[XLEN-1];
  assign b_neg_c = is_signed_op(req_op) & b[XLEN-1];
  assign mag_a_c = a_neg_c ? (~a + XLEN'(1)) : a;
  assign mag_b_c = b_neg_c ? (~b + XLEN'(1)) : b;

  div_iter #(
    .ITER (DIV_ITER)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_c),
    .dividend  (mag_a_c),
    .divisor   (mag_b_c),
    .quotient  (quo_raw),
    .remainder (rem_raw)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and latency counter; flush always returns to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && is_long_op(req_op) && !flush) begin
          accept_c = 1'b1;
          cnt_d    = '0;
          state_d  = is_mul_op(req_op) ? MUL : DIV;
        end
      end
      MUL: begin
        if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // The FIX cycle is the completion cycle unless a flush cancels it.
  assign fix_c = (state_q == FIX) && !flush;

  // Sign fixup of the raw unsigned product / quotient / remainder.
  assign prod_fix_c = neg_quo_q ? (~mul_res + (2*XLEN)'(1)) : mul_res;
  assign quo_fix_c  = neg_quo_q ? (~quo_raw + XLEN'(1)) : quo_raw;
  assign rem_fix_c  = neg_rem_q ? (~rem_raw + XLEN'(1)) : rem_raw;

  // Operation context, multiplier interface and architectural HI/LO/result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q        <= MD_MULT;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
    end else begin
      mul_start_q <= accept_c && is_mul_op(req_op);
      if (accept_c) begin
        op_q       <= muldiv_op_t'(req_op);
        neg_quo_q  <= a_neg_c ^ b_neg_c;
        neg_rem_q  <= a_neg_c;
        div_zero_q <= (b == '0);
        mul_a_q    <= mag_a_c;
        mul_b_q    <= mag_b_c;
      end
      if ((state_q == IDLE) && req_valid && !flush) begin
        if (req_op == MD_MTHI) hi_q <= a;
        if (req_op == MD_MTLO) lo_q <= a;
      end
      if (fix_c) begin
        case (op_q)
          MD_MULT, MD_MULTU: begin
            hi_q <= prod_fix_c[2*XLEN-1:XLEN];
            lo_q <= prod_fix_c[XLEN-1:0];
          end
          MD_DIV, MD_DIVU: begin
            // Divide by zero leaves HI/LO alone; the ALU raises the exception.
            if (!div_zero_q) begin
              hi_q <= rem_fix_c;
              lo_q <= quo_fix_c;
            end
          end
          MD_MUL:  result_q <= prod_fix_c[XLEN-1:0];
          default: ;
        endcase
      end
    end
  end

  // The product arrives in the completion cycle, so result bypasses it then and holds it after.
  assign result    = (fix_c && (op_q == MD_MUL)) ? prod_fix_c[XLEN-1:0] : result_q;
  assign done      = fix_c;
  assign stall     = req_valid && is_long_op(req_op) && !fix_c;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
